// File: rtl/add_in_responder.sv
// add_in_responder: buffers a/b operand pairs in a FIFO and returns registered a+b with carry over valid/ready.
module add_in_responder #(
    parameter int ADD_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADD_WIDTH-1:0]          a,
    input  logic [ADD_WIDTH-1:0]          b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADD_WIDTH-1:0]          sum,
    output logic                          carry,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [15:0]                   txn_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    logic [2*ADD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]          occ_q, occ_d;
    logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d, carry_q, carry_d;
    logic [ADD_WIDTH-1:0]   sum_q, sum_d;
    logic [15:0]            txn_q, txn_d;
    logic [2*ADD_WIDTH-1:0] head;
    logic                   push, pop;
    always_comb begin
        push        = in_valid && in_ready_q;
        pop         = (occ_q != '0) && (!out_valid_q || out_ready);
        head        = fifo_mem[rd_ptr_q];
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        occ_d       = occ_q + OW'(push) - OW'(pop);
        in_ready_d  = occ_d < OW'(FIFO_DEPTH);
        {carry_d, sum_d} = pop ? {1'b0, head[2*ADD_WIDTH-1:ADD_WIDTH]} + {1'b0, head[ADD_WIDTH-1:0]}
                               : {carry_q, sum_q};
        out_valid_d = pop ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        txn_d       = (out_valid_q && out_ready && txn_q != 16'hFFFF) ? txn_q + 16'd1 : txn_q;
    end
    // storage entries are not reset; only the pointers define what is live
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {a, b};
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            txn_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            txn_q       <= txn_d;
        end
    end
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign occupancy = occ_q;
    assign txn_count = txn_q;
endmodule

// File: tb/tb_add_in_responder.sv
// tb_add_in_responder: random and directed stimulus against a queue-based reference model.
module tb_add_in_responder;
    localparam int W = 4;
    localparam int D = 4;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, carry;
    logic [W-1:0] a = '0, b = '0, sum;
    logic [$clog2(D):0] occupancy;
    logic [15:0] txn_count;
    int n_checks = 0, n_fail = 0;
    logic [2*W-1:0] q[$];
    logic m_ov = 1'b0, m_rdy = 1'b0, m_carry = 1'b0, last_push = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic [15:0] m_txn = '0;
    logic [W:0] got[$];
    int acc;
    logic [15:0] base;

    add_in_responder #(.ADD_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry),
        .occupancy(occupancy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
        end
    endtask

    // Reference: a queue of accepted pairs plus one result slot, advanced once per edge.
    task automatic model_edge();
        logic [2*W-1:0] p;
        logic pop;
        last_push = 1'b0;
        if (rst) begin
            q.delete();
            m_ov = 1'b0; m_rdy = 1'b0; m_sum = '0; m_carry = 1'b0; m_txn = '0;
        end else begin
            pop = (q.size() > 0) && (!m_ov || out_ready);
            if (m_ov && out_ready && m_txn != 16'hFFFF) m_txn++;
            last_push = in_valid && m_rdy;
            if (pop) begin
                p = q.pop_front();
                {m_carry, m_sum} = (W+1)'(p[2*W-1:W]) + (W+1)'(p[W-1:0]);
                m_ov = 1'b1;
            end else if (out_ready) m_ov = 1'b0;
            if (last_push) q.push_back({a, b});
            m_rdy = q.size() < D;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("sum_carry", 32'({carry, sum}), 32'({m_carry, m_sum}));
        chk("txn_count", 32'(txn_count), 32'(m_txn));
    endtask

    initial begin
        cyc(); cyc();
        chk("reset_zero", 32'({in_ready, out_valid, carry, sum, occupancy, txn_count}), 0);
        // basic
        rst = 1'b0;
        cyc();
        chk("basic_ready", 32'(in_ready), 1);
        a = 4'd3; b = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_sum", 32'({carry, sum}), 8);
        cyc();
        chk("basic_txn", 32'(txn_count), 1);
        // carry and wrap
        a = 4'hF; b = 4'h1; in_valid = 1'b1;
        cyc();
        a = 4'hF; b = 4'hF;
        cyc();
        in_valid = 1'b0;
        chk("carry_f1", 32'({carry, sum}), 32'h10);
        cyc();
        chk("carry_ff", 32'({carry, sum}), 32'h1E);
        cyc(); cyc();
        // fill under backpressure
        out_ready = 1'b0; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            a = W'(acc + 1); b = W'(acc + 1);
            cyc();
            if (last_push) acc++;
        end
        in_valid = 1'b0;
        chk("fill_accepted", 32'(acc), D + 1);
        chk("fill_occ", 32'(occupancy), D);
        chk("fill_ready", 32'(in_ready), 0);
        chk("fill_hold", 32'({out_valid, carry, sum}), 32'h22);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) got.push_back({carry, sum});
            cyc();
        end
        chk("drain_count", 32'(got.size()), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) chk("drain_order", 32'(got[k]), 32'(2 * (k + 1)));
        // reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = W'(i); b = W'(i + 1);
            cyc();
        end
        in_valid = 1'b0;
        chk("mid_occ", 32'(occupancy), 3);
        chk("mid_valid", 32'(out_valid), 1);
        rst = 1'b1;
        cyc();
        chk("mid_reset_zero", 32'({in_ready, out_valid, carry, sum, occupancy, txn_count}), 0);
        rst = 1'b0; out_ready = 1'b1;
        cyc();
        a = 4'd7; b = 4'd2; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("post_reset_sum", 32'({out_valid, carry, sum}), 32'h29);
        cyc();
        chk("no_stale", 32'(out_valid), 0);
        // streaming
        base = m_txn; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = W'(i); b = W'(i + 2);
            cyc();
            chk("stream_occ_le1", 32'(occupancy <= 1), 1);
        end
        in_valid = 1'b0;
        cyc(); cyc();
        chk("stream_txn", 32'(txn_count), 32'(base + 16'd20));
        // random traffic with occasional reset; initiator holds pairs until accepted
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || last_push) begin
                in_valid = 1'($urandom);
                a = W'($urandom); b = W'($urandom);
            end
            cyc();
        end
        rst = 1'b0;
        // saturation
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            a = W'($urandom); b = W'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        cyc(); cyc();
        chk("txn_saturate", 32'(txn_count), 32'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
